mem_ctrl: RTL and testbench

Responder side of the instruction-fetch miss interface. It serves icache word fetches and LSB loads/stores over the single byte-wide RAM/IO bus, one byte per cycle. It sits between icache/LSB and the top-level RAM port. It arbitrates requests, sequences byte addresses, assembles read words and pulses completion.

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial RAM/IO responder: state encodings and IO window base.
package mem_ctrl_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [1:0] MC_IDLE   = 2'd0;
   localparam logic [1:0] MC_IFETCH = 2'd1;
   localparam logic [1:0] MC_LOAD   = 2'd2;
   localparam logic [1:0] MC_STORE  = 2'd3;

   localparam logic [31:0] MC_IO_BASE = 32'h0003_0000;

endpackage

// File: rtl/mem_ctrl.sv
// Serves icache word fetches and LSB loads/stores over the byte-wide RAM/IO bus,
// one byte per cycle, with LSB priority and a stalled IO store window.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// MC_IDLE   | waiting for a request; blocked while a done pulse is high
// MC_IFETCH | stepping 4 byte addresses for icache, assembling the word
// MC_LOAD   | stepping LSB_size byte addresses, assembling the load
// MC_STORE  | driving one data byte per cycle with mem_wr high
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [31:0] IO_BASE = MC_IO_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic        io_buffer_full,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic [31:0] IC_addr,
   input  logic        IC_addr_sgn,
   output logic [31:0] IC_val,
   output logic        IC_val_sgn,
   input  logic [31:0] LSB_addr,
   input  logic        LSB_sgn,
   input  logic        LSB_wr,
   input  logic [2:0]  LSB_size,
   input  logic [31:0] LSB_data,
   output logic [31:0] LSB_val,
   output logic        LSB_val_sgn
);

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] data_q, data_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  dout_q, dout_d;
   logic        wr_q, wr_d;
   logic [31:0] ic_val_q, ic_val_d;
   logic        ic_sgn_q, ic_sgn_d;
   logic [31:0] lsb_val_q, lsb_val_d;
   logic        lsb_sgn_q, lsb_sgn_d;

   logic [2:0]  cnt_inc;
   logic [2:0]  cnt_dec;
   logic [31:0] next_a;
   logic [31:0] din_shifted;
   logic        io_blocked;

   assign cnt_inc     = cnt_q + 3'd1;
   assign cnt_dec     = cnt_q - 3'd1;
   assign next_a      = addr_q + {29'd0, cnt_inc};
   assign din_shifted = {24'd0, mem_din} << {cnt_dec, 3'b000};
   assign io_blocked  = LSB_wr && io_buffer_full && (LSB_addr >= IO_BASE);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      size_d    = size_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      asm_d     = asm_q;
      mem_a_d   = mem_a_q;
      dout_d    = dout_q;
      wr_d      = wr_q;
      ic_val_d  = ic_val_q;
      ic_sgn_d  = FALSE;
      lsb_val_d = lsb_val_q;
      lsb_sgn_d = FALSE;

      case (state_q)
         MC_IDLE: begin
            // The pulse cycle is skipped so the requester can drop its request first.
            if (!rollback && !ic_sgn_q && !lsb_sgn_q) begin
               if (LSB_sgn) begin
                  if (!io_blocked) begin
                     addr_d  = LSB_addr;
                     data_d  = LSB_data;
                     size_d  = (LSB_size == 3'd4) ? 3'd4 : ((LSB_size == 3'd2) ? 3'd2 : 3'd1);
                     mem_a_d = LSB_addr;
                     cnt_d   = 3'd0;
                     asm_d   = 32'd0;
                     if (LSB_wr) begin
                        wr_d    = TRUE;
                        dout_d  = LSB_data[7:0];
                        state_d = MC_STORE;
                     end else begin
                        state_d = MC_LOAD;
                     end
                  end
               end else if (IC_addr_sgn) begin
                  addr_d  = IC_addr;
                  size_d  = 3'd4;
                  mem_a_d = IC_addr;
                  cnt_d   = 3'd0;
                  asm_d   = 32'd0;
                  state_d = MC_IFETCH;
               end
            end
         end

         MC_IFETCH, MC_LOAD: begin
            if (rollback) begin
               state_d = MC_IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc < size_q) mem_a_d = next_a;
               if (cnt_q != 3'd0) begin
                  if (cnt_q == size_q) begin
                     state_d = MC_IDLE;
                     if (state_q == MC_IFETCH) begin
                        ic_val_d = asm_q | din_shifted;
                        ic_sgn_d = TRUE;
                     end else begin
                        lsb_val_d = asm_q | din_shifted;
                        lsb_sgn_d = TRUE;
                     end
                  end else begin
                     asm_d = asm_q | din_shifted;
                  end
               end
            end
         end

         MC_STORE: begin
            // Stores are already committed, so rollback does not cut them short.
            if (cnt_inc < size_q) begin
               cnt_d   = cnt_inc;
               mem_a_d = next_a;
               dout_d  = 8'(data_q >> {cnt_inc, 3'b000});
            end else begin
               wr_d      = FALSE;
               lsb_sgn_d = TRUE;
               state_d   = MC_IDLE;
            end
         end

         default: state_d = MC_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MC_IDLE;
         addr_q    <= 32'd0;
         size_q    <= 3'd0;
         data_q    <= 32'd0;
         cnt_q     <= 3'd0;
         asm_q     <= 32'd0;
         mem_a_q   <= 32'd0;
         dout_q    <= 8'd0;
         wr_q      <= FALSE;
         ic_val_q  <= 32'd0;
         ic_sgn_q  <= FALSE;
         lsb_val_q <= 32'd0;
         lsb_sgn_q <= FALSE;
      end else if (rdy) begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         asm_q     <= asm_d;
         mem_a_q   <= mem_a_d;
         dout_q    <= dout_d;
         wr_q      <= wr_d;
         ic_val_q  <= ic_val_d;
         ic_sgn_q  <= ic_sgn_d;
         lsb_val_q <= lsb_val_d;
         lsb_sgn_q <= lsb_sgn_d;
      end
   end

   assign mem_a       = mem_a_q;
   assign mem_dout    = dout_q;
   assign mem_wr      = wr_q & rdy;
   assign IC_val      = ic_val_q;
   assign IC_val_sgn  = ic_sgn_q;
   assign LSB_val     = lsb_val_q;
   assign LSB_val_sgn = lsb_sgn_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, table of LSB transactions, and
// hand sequences for arbitration, IO stall, rollback, freeze and reset.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, io_buffer_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [31:0] IC_addr, IC_val;
   logic        IC_addr_sgn, IC_val_sgn;
   logic [31:0] LSB_addr, LSB_data, LSB_val;
   logic        LSB_sgn, LSB_wr, LSB_val_sgn;
   logic [2:0]  LSB_size;

   int checks = 0;
   int errors = 0;

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .IC_addr(IC_addr), .IC_addr_sgn(IC_addr_sgn),
      .IC_val(IC_val), .IC_val_sgn(IC_val_sgn), .LSB_addr(LSB_addr), .LSB_sgn(LSB_sgn),
      .LSB_wr(LSB_wr), .LSB_size(LSB_size), .LSB_data(LSB_data), .LSB_val(LSB_val),
      .LSB_val_sgn(LSB_val_sgn)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(int i);
      case (i)
         32'h100: return 8'h13;
         32'h101: return 8'h05;
         32'h102: return 8'h00;
         32'h103: return 8'h00;
         32'h204: return 8'hFE;
         32'h205: return 8'hFF;
         default: return i[7:0];
      endcase
   endfunction

   // RAM model: read data one cycle after the address, frozen with rdy like the top level.
   logic [7:0]  ram [0:4095];
   logic [39:0] wlog [$];
   int          ic_pulses = 0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
         mem_din <= 8'h00;
      end else if (rdy) begin
         mem_din <= ram[mem_a[11:0]];
         if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      end
   end

   always @(posedge clk) if (mem_wr) wlog.push_back({mem_a, mem_dout});
   always @(negedge clk) if (IC_val_sgn) ic_pulses++;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   logic [31:0] a_trace [0:31];
   logic        w_trace [0:31];

   // Called at a negedge with the DUT idle; returns one negedge after the done pulse.
   task automatic lsb_txn(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] data, input int rb_at, input int frz_at,
                          output logic [31:0] val, output int lat);
      LSB_wr = wr; LSB_size = size; LSB_addr = addr; LSB_data = data; LSB_sgn = 1'b1;
      lat = -1; val = 32'hx;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         a_trace[i] = mem_a;
         w_trace[i] = mem_wr;
         rollback = (i == rb_at);
         rdy = !(frz_at > 0 && i >= frz_at && i < frz_at + 3);
         if (LSB_val_sgn) begin
            lat = i;
            val = LSB_val;
            break;
         end
      end
      rollback = 1'b0;
      rdy = 1'b1;
      LSB_sgn = 1'b0;
      @(negedge clk);
      chk("lsb_pulse_width", {31'd0, LSB_val_sgn}, 32'd0);
   endtask

   typedef struct {
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_val;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [31:0] v, lv, iv;
      int lat, lsb_lat, ic_lat, bad, p0;

      vecs[0] = '{1'b0, 3'd1, 32'h010, 32'h0, 32'h0000_0010};
      vecs[1] = '{1'b0, 3'd4, 32'h021, 32'h0, 32'h2423_2221};
      vecs[2] = '{1'b0, 3'd2, 32'h204, 32'h0, 32'h0000_FFFE};
      vecs[3] = '{1'b0, 3'd2, 32'h0FF, 32'h0, 32'h0000_13FF};
      vecs[4] = '{1'b1, 3'd2, 32'h400, 32'h1234_5678, 32'h0};
      vecs[5] = '{1'b0, 3'd4, 32'h400, 32'h0, 32'h0302_5678};
      vecs[6] = '{1'b1, 3'd1, 32'h410, 32'h0000_00AB, 32'h0};
      vecs[7] = '{1'b0, 3'd1, 32'h410, 32'h0, 32'h0000_00AB};
      vecs[8] = '{1'b0, 3'd4, 32'h300, 32'h0, 32'hDEAD_BEEF};
      vecs[9] = '{1'b0, 3'd4, 32'h3FE, 32'h0, 32'h5678_FFFE};

      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
      IC_addr = 32'h0; IC_addr_sgn = 1'b0;
      LSB_addr = 32'h0; LSB_data = 32'h0; LSB_sgn = 1'b0; LSB_wr = 1'b0; LSB_size = 3'd0;
      repeat (3) @(negedge clk);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
      chk("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
      chk("rst_ic", {IC_val[30:0], IC_val_sgn}, 32'h0);
      chk("rst_lsb", {LSB_val[30:0], LSB_val_sgn}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Icache fetch: address walk, pulse 5 edges after accept
      IC_addr = 32'h100; IC_addr_sgn = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk("if_mem_a", mem_a, 32'h100 + ((i > 4) ? 32'd3 : 32'(i - 1)));
         chk("if_early_pulse", {31'd0, IC_val_sgn}, 32'd0);
      end
      @(negedge clk);
      chk("if_pulse", {31'd0, IC_val_sgn}, 32'd1);
      chk("if_val", IC_val, 32'h0000_0513);
      IC_addr_sgn = 1'b0;
      @(negedge clk);
      chk("if_pulse_width", {31'd0, IC_val_sgn}, 32'd0);
      chk("if_val_hold", IC_val, 32'h0000_0513);

      // Simultaneous requests: LSB first, icache after one idle cycle
      LSB_wr = 1'b0; LSB_size = 3'd2; LSB_addr = 32'h204; LSB_sgn = 1'b1;
      IC_addr = 32'h020; IC_addr_sgn = 1'b1;
      lsb_lat = -1; ic_lat = -1; lv = 32'h0; iv = 32'h0;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (LSB_val_sgn && lsb_lat < 0) begin lsb_lat = i; lv = LSB_val; LSB_sgn = 1'b0; end
         if (IC_val_sgn) begin ic_lat = i; iv = IC_val; IC_addr_sgn = 1'b0; break; end
      end
      LSB_sgn = 1'b0; IC_addr_sgn = 1'b0;
      chk("sim_lsb_lat", lsb_lat, 32'd4);
      chk("sim_lsb_val", lv, 32'h0000_FFFE);
      chk("sim_ic_lat", ic_lat, 32'd11);
      chk("sim_ic_val", iv, 32'h2322_2120);
      @(negedge clk);

      // 4-byte store: byte order on the bus
      wlog.delete();
      lsb_txn(1'b1, 3'd4, 32'h300, 32'hDEAD_BEEF, 0, 0, v, lat);
      chk("st_lat", lat, 32'd5);
      chk("st_writes", wlog.size(), 32'd4);
      for (int k = 0; k < 4 && k < wlog.size(); k++)
         chk("st_byte", {24'd0, wlog[k][7:0]} | ({wlog[k][39:8] - 32'h300, 8'h00} & 32'hFF00),
             {24'd0, 8'(32'hDEAD_BEEF >> (8 * k))} | (32'(k) << 8));
      chk("st_wr_low", {31'd0, mem_wr}, 32'd0);

      for (int n = 0; n < 10; n++) begin
         lsb_txn(vecs[n].wr, vecs[n].size, vecs[n].addr, vecs[n].data, 0, 0, v, lat);
         chk("vec_lat", lat, vecs[n].wr ? 32'(vecs[n].size) + 1 : 32'(vecs[n].size) + 2);
         if (!vecs[n].wr) chk("vec_val", v, vecs[n].exp_val);
      end

      // IO stall: blocked store holds off icache too
      io_buffer_full = 1'b1; wlog.delete();
      LSB_wr = 1'b1; LSB_size = 3'd1; LSB_addr = 32'h3_0000; LSB_data = 32'h41; LSB_sgn = 1'b1;
      IC_addr = 32'h010; IC_addr_sgn = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (mem_wr || LSB_val_sgn || IC_val_sgn) bad++;
      end
      chk("io_stall", bad, 32'd0);
      io_buffer_full = 1'b0;
      @(negedge clk);
      chk("io_wr", {31'd0, mem_wr}, 32'd1);
      chk("io_addr", mem_a, 32'h3_0000);
      chk("io_dout", {24'd0, mem_dout}, 32'h41);
      @(negedge clk);
      chk("io_pulse", {31'd0, LSB_val_sgn}, 32'd1);
      LSB_sgn = 1'b0;
      ic_lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (IC_val_sgn) begin ic_lat = i; iv = IC_val; break; end
      end
      IC_addr_sgn = 1'b0;
      chk("io_ic_lat", ic_lat, 32'd7);
      chk("io_ic_val", iv, 32'h1312_1110);
      @(negedge clk);

      // Rollback 2 cycles into a fetch: no pulse, idle at once
      p0 = ic_pulses;
      IC_addr = 32'h100; IC_addr_sgn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rollback = 1'b1; IC_addr_sgn = 1'b0;
      @(negedge clk);
      rollback = 1'b0;
      lsb_txn(1'b0, 3'd1, 32'h010, 32'h0, 0, 0, v, lat);
      chk("rb_if_next_lat", lat, 32'd3);
      chk("rb_if_next_val", v, 32'h10);
      repeat (6) @(negedge clk);
      chk("rb_if_no_pulse", ic_pulses - p0, 32'd0);

      // Rollback during a store: it still completes
      wlog.delete();
      lsb_txn(1'b1, 3'd4, 32'h500, 32'hCAFE_F00D, 2, 0, v, lat);
      chk("rb_st_lat", lat, 32'd5);
      chk("rb_st_writes", wlog.size(), 32'd4);
      if (wlog.size() == 4) chk("rb_st_last", wlog[3], {32'h503, 8'hCA});

      // Freeze for 3 cycles mid-load
      lsb_txn(1'b0, 3'd4, 32'h021, 32'h0, 0, 2, v, lat);
      chk("frz_lat", lat, 32'd9);
      chk("frz_val", v, 32'h2423_2221);
      bad = 0;
      for (int i = 3; i <= 5; i++) if (a_trace[i] !== 32'h022 || w_trace[i] !== 1'b0) bad++;
      chk("frz_hold", bad, 32'd0);

      // Reset in the middle of a store
      LSB_wr = 1'b1; LSB_size = 3'd4; LSB_addr = 32'h600; LSB_data = 32'h1122_3344; LSB_sgn = 1'b1;
      @(negedge clk);
      chk("mr_wr_before", {31'd0, mem_wr}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_wr", {31'd0, mem_wr}, 32'd0);
      chk("mr_mem_a", mem_a, 32'h0);
      chk("mr_lsb_val", LSB_val, 32'h0);
      rst = 1'b0; LSB_sgn = 1'b0;
      @(negedge clk);
      chk("mr_no_pulse", {31'd0, LSB_val_sgn}, 32'd0);
      chk("mr_idle", {31'd0, mem_wr}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
